// File: rtl/xres_pad_ctrl.sv
// XRES pad sequencer: safe pad-enable ordering, input sync/debounce with glitch count,
// and sys_resetb generation with minimum hold and stretched release.
module xres_pad_ctrl #(
  parameter int CNT_W          = 8,
  parameter int PAD_EN_CYCLES  = 8,
  parameter int DEB_CYCLES     = 16,
  parameter int MIN_HOLD       = 32,
  parameter int RELEASE_CYCLES = 16,
  parameter int GLITCH_W       = 8
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                xres_pad_i,
  input  logic                cfg_inp_sel,
  input  logic                cfg_pullup_dis,
  input  logic                glitch_clr,
  output logic                pad_enable_h,
  output logic                pad_en_vddio_sig_h,
  output logic                pad_enable_vddio,
  output logic                pad_inp_sel_h,
  output logic                pad_disable_pullup_h,
  output logic                pad_ready,
  output logic                sys_resetb,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_EN_SIG,
    ST_EN_H,
    ST_EN_VDDIO,
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } state_t;

  localparam logic [CNT_W-1:0] PAD_LAST  = CNT_W'(PAD_EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_CYCLES - 1);

  logic                sync1_q, sync_q;
  logic                filt_q, filt_d;
  logic [CNT_W-1:0]    deb_cnt_q, deb_cnt_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                glitch_evt;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                en_sig_q, en_h_q, en_vddio_q;
  logic                inp_sel_q, pullup_dis_q, ready_q, sysrst_q;

  // A glitch is the synchronised input falling back to the filtered value mid-debounce.
  assign glitch_evt = (sync_q == filt_q) && (deb_cnt_q != '0);

  always_comb begin
    filt_d    = filt_q;
    deb_cnt_d = '0;
    if (sync_q != filt_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        filt_d = sync_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    glitch_d = glitch_q;
    if (glitch_clr) begin
      glitch_d = '0;
    end else if (glitch_evt && (glitch_q != '1)) begin
      glitch_d = glitch_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync1_q   <= 1'b0;
      sync_q    <= 1'b0;
      filt_q    <= 1'b0;
      deb_cnt_q <= '0;
      glitch_q  <= '0;
    end else begin
      sync1_q   <= xres_pad_i;
      sync_q    <= sync1_q;
      filt_q    <= filt_d;
      deb_cnt_q <= deb_cnt_d;
      glitch_q  <= glitch_d;
    end
  end

  // EN_VDDIO_SIG_H goes up before ENABLE_H so the pad never sees enable_h without it.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q      <= ST_OFF;
      cnt_q        <= '0;
      en_sig_q     <= 1'b0;
      en_h_q       <= 1'b0;
      en_vddio_q   <= 1'b0;
      inp_sel_q    <= 1'b0;
      pullup_dis_q <= 1'b0;
      ready_q      <= 1'b0;
      sysrst_q     <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      case (state_q)
        ST_OFF: begin
          if (cnt_q == PAD_LAST) begin
            state_q      <= ST_EN_SIG;
            cnt_q        <= '0;
            en_sig_q     <= 1'b1;
            inp_sel_q    <= cfg_inp_sel;
            pullup_dis_q <= cfg_pullup_dis;
          end
        end
        ST_EN_SIG: begin
          if (cnt_q == PAD_LAST) begin
            state_q <= ST_EN_H;
            cnt_q   <= '0;
            en_h_q  <= 1'b1;
          end
        end
        ST_EN_H: begin
          if (cnt_q == PAD_LAST) begin
            state_q    <= ST_EN_VDDIO;
            cnt_q      <= '0;
            en_vddio_q <= 1'b1;
          end
        end
        ST_EN_VDDIO: begin
          if (cnt_q == PAD_LAST) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            ready_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          sysrst_q <= 1'b0;
          if (cnt_q == HOLD_LAST) begin
            cnt_q <= cnt_q;
            if (filt_q) begin
              state_q <= ST_RELEASE;
              cnt_q   <= '0;
            end
          end
        end
        ST_RELEASE: begin
          if (!filt_q) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
          end else if (cnt_q == REL_LAST) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            sysrst_q <= 1'b1;
          end
        end
        ST_RUN: begin
          cnt_q <= '0;
          if (!filt_q) begin
            state_q  <= ST_HOLD;
            sysrst_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_OFF;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign pad_en_vddio_sig_h   = en_sig_q;
  assign pad_enable_h         = en_h_q;
  assign pad_enable_vddio     = en_vddio_q;
  assign pad_inp_sel_h        = inp_sel_q;
  assign pad_disable_pullup_h = pullup_dis_q;
  assign pad_ready            = ready_q;
  assign sys_resetb           = sysrst_q;
  assign glitch_cnt           = glitch_q;

endmodule
